jtag_shift_master: RTL and testbench

- Command-driven JTAG master that generates TCK/TMS/TDI and captures TDO for the CPLD breakout's 8-way JTAG header.
- Lives in a host-side controller, e.g. a second CPLD/FPGA acting as programmer, directly upstream of the header.
- A command either walks the TAP state machine with a TMS bit sequence or shifts up to 32 data bits through IR/DR, returning captured TDO bits.

---
 rtl/jtag_shift_master.sv | 213 +++++++++++++++++++++
 tb/tb_jtag_shift_master.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_master.sv
// jtag_shift_master: command-driven JTAG master for a JTAG header.
//
// A command either walks the TAP with a TMS bit sequence (cmd_type=0) or
// shifts up to DW bits of TDI through IR/DR while capturing TDO
// (cmd_type=1). Bits go out LSB first. TCK runs at f_clk / (2*CLKDIV).
//
// Ports:
//   clk, resetb             system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_type                0 = TMS sequence, 1 = data shift
//   cmd_len                 bit count 0..32 (larger values clamp to DW)
//   cmd_data                TMS bits (type 0) or TDI bits (type 1)
//   cmd_exit                type 1: TMS=1 on the last bit (Shift -> Exit1)
//   rsp_valid/rsp_ready     response handshake, rsp_data = captured TDO
//   busy                    command in progress or response pending
//   tck, tms, tdi, tdo      JTAG pins; tdo is asynchronous to clk
//
// Every output is a flop or a decode of the state flop, so there is no
// combinational path from any input to tck/tms/tdi.

module jtag_shift_master #(
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_type,
  input  logic [5:0]    cmd_len,
  input  logic [DW-1:0] cmd_data,
  input  logic          cmd_exit,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          tck,
  output logic          tms,
  output logic          tdi,
  input  logic          tdo
);

  localparam int unsigned IdxW    = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [5:0]  MaxLen  = 6'(DW);
  localparam logic [7:0]  DivLast = 8'(CLKDIV - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StResp} state_e;

  state_e        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [5:0]    len_q, len_d;
  logic          type_q, type_d;
  logic          exit_q, exit_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          tdo_meta_q, tdo_sync_q;

  logic [5:0]    eff_len;
  logic          div_last;
  logic          last_bit;

  // Bit-load request: fields of the command being driven and the bit index
  // whose TMS/TDI values go onto the pins as the FSM enters LOW.
  logic          load_bit;
  logic [5:0]    load_idx;
  logic          f_type;
  logic          f_exit;
  logic [DW-1:0] f_data;
  logic [5:0]    f_len;

  assign eff_len  = (cmd_len > MaxLen) ? MaxLen : cmd_len;
  assign div_last = (div_q == DivLast);
  assign last_bit = (bit_q == len_q - 6'd1);

  // TDO crosses into the clk domain; idles high like a pulled-up line.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tdo_meta_q <= 1'b1;
      tdo_sync_q <= 1'b1;
    end else begin
      tdo_meta_q <= tdo;
      tdo_sync_q <= tdo_meta_q;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      len_q      <= '0;
      type_q     <= 1'b0;
      exit_q     <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      len_q      <= len_d;
      type_q     <= type_d;
      exit_q     <= exit_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    len_d      = len_q;
    type_d     = type_q;
    exit_d     = exit_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    load_bit   = 1'b0;
    load_idx   = bit_q;
    f_type     = type_q;
    f_exit     = exit_q;
    f_data     = data_q;
    f_len      = len_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          type_d     = cmd_type;
          exit_d     = cmd_exit;
          data_d     = cmd_data;
          len_d      = eff_len;
          rsp_data_d = '0;
          div_d      = '0;
          bit_d      = '0;
          if (eff_len == 6'd0) begin
            // Zero-length TMS walks are a no-op; zero-length shifts still
            // owe the consumer an (empty) response.
            if (cmd_type) state_d = StResp;
          end else begin
            state_d  = StLow;
            load_bit = 1'b1;
            load_idx = 6'd0;
            // Latched fields only become visible next cycle.
            f_type   = cmd_type;
            f_exit   = cmd_exit;
            f_data   = cmd_data;
            f_len    = eff_len;
          end
        end
      end

      StLow: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d   = '0;
          state_d = StHigh;
        end
      end

      StHigh: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d = '0;
          // Sample as late as possible in the high phase to give TDO the
          // longest settle time after the preceding falling edge.
          if (type_q) rsp_data_d[bit_q[IdxW-1:0]] = tdo_sync_q;
          if (last_bit) begin
            state_d = type_q ? StResp : StIdle;
          end else begin
            bit_d    = bit_q + 6'd1;
            state_d  = StLow;
            load_bit = 1'b1;
            load_idx = bit_q + 6'd1;
          end
        end
      end

      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // TMS/TDI change together with the falling TCK edge that opens LOW.
    if (load_bit) begin
      if (f_type) begin
        tdi_d = f_data[load_idx[IdxW-1:0]];
        tms_d = f_exit & (load_idx == f_len - 6'd1);
      end else begin
        tms_d = f_data[load_idx[IdxW-1:0]];
        tdi_d = 1'b1;
      end
    end
  end

  assign tck       = (state_q == StHigh);
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_jtag_shift_master.sv
// Self-checking bench for jtag_shift_master: per-feature tasks, a response
// scoreboard queue, a TDO model (pattern or TDI loopback) and a TAP model.

module tb_jtag_shift_master;

  localparam int CLKDIV = 4;
  localparam int DW     = 32;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6;
  localparam int EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12;
  localparam int PAIR = 13, EX2IR = 14, UPIR = 15;

  logic          clk;
  logic          resetb;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_type;
  logic [5:0]    cmd_len;
  logic [DW-1:0] cmd_data;
  logic          cmd_exit;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          tck;
  logic          tms;
  logic          tdi;
  logic          tdo;

  int vectors     = 0;
  int miscompares = 0;

  // Pin monitors.
  int rise_cnt  = 0;
  int fall_cnt  = 0;
  int tap_state = TLR;
  bit tms_hist[$];
  bit tdi_hist[$];

  // TDO model: loopback of TDI, or a pattern advanced on each TCK fall.
  logic          loop_mode;
  logic [31:0]   tdo_pat;
  int            fall_base;
  logic [31:0]   tdo_shift;

  logic [DW-1:0] exp_q[$];

  jtag_shift_master #(
    .CLKDIV(CLKDIV),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .resetb   (resetb),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .cmd_exit (cmd_exit),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tdo      (tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tap_next(input int s, input bit t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PADR;
      PADR:    return t ? EX2DR : PADR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAIR;
      PAIR:    return t ? EX2IR : PAIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    rise_cnt  <= rise_cnt + 1;
    tap_state <= tap_next(tap_state, tms);
    tms_hist.push_back(tms);
    tdi_hist.push_back(tdi);
  end

  always @(negedge tck) fall_cnt <= fall_cnt + 1;

  assign tdo_shift = tdo_pat >> (fall_cnt - fall_base);
  assign tdo       = loop_mode ? tdi : tdo_shift[0];

  // Called at a negedge with cmd_ready expected high; returns at cycle 1.
  task automatic issue(input bit t, input logic [5:0] l, input logic [31:0] d, input bit e);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_exit  = e;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Starts at cycle 1 after issue; pops the scoreboard when rsp_valid rises.
  task automatic wait_rsp(input string name, input int budget, input int exp_cycle);
    int            j;
    bit            got;
    logic [DW-1:0] exp;
    got = 1'b0;
    for (j = 1; j <= budget; j++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", name, budget);
    end else begin
      if (j != exp_cycle) begin
        miscompares++;
        $display("FAIL %s_cycle: rsp_valid at cycle %0d required %0d", name, j, exp_cycle);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_data: unexpected response %h", name, rsp_data);
      end else begin
        exp = exp_q.pop_front();
        if (rsp_data !== exp) begin
          miscompares++;
          $display("FAIL %s_data: rsp_data=%h required %h", name, rsp_data, exp);
        end
      end
    end
  endtask

  task automatic ack(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ack: rsp_valid=%b cmd_ready=%b required 0 1", name, rsp_valid,
               cmd_ready);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int j;
    for (j = 0; j < budget && cmd_ready !== 1'b1; j++) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle: cmd_ready=%b required 1 within %0d cycles", name, cmd_ready,
               budget);
    end
  endtask

  task automatic test_reset();
    int seen;
    resetb = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b011100 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL reset_values: tck/tms/tdi/rdy/rv/busy=%b rsp_data=%h required 011100 0",
               {tck, tms, tdi, cmd_ready, rsp_valid, busy}, rsp_data);
    end
    resetb = 1'b1;
    @(negedge clk);
    // Abort a shift in the middle of the first HIGH phase.
    loop_mode = 1'b1;
    issue(1'b1, 6'd8, 32'h0000_00FE, 1'b1);
    repeat (5) @(negedge clk);
    vectors++;
    if (tck !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_high: tck=%b required 1", tck);
    end
    resetb = 1'b0;
    #1;
    vectors++;
    if ({tck, tms, tdi, rsp_valid} !== 4'b0110) begin
      miscompares++;
      $display("FAIL reset_async: tck/tms/tdi/rv=%b required 0110", {tck, tms, tdi, rsp_valid});
    end
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_rsp: rsp_valid high %0d cycles required 0", seen);
    end
  endtask

  task automatic test_tms();
    int   base;
    logic exp_tck;
    bit   exp_tms;
    base = rise_cnt;
    issue(1'b0, 6'd5, 32'h0000_001F, 1'b0);
    for (int j = 1; j <= 41; j++) begin
      exp_tck = (j <= 40) ? 1'(((j - 1) / CLKDIV) % 2) : 1'b0;
      vectors++;
      if (tck !== exp_tck) begin
        miscompares++;
        $display("FAIL tms_tck_wave: cycle %0d tck=%b required %b", j, tck, exp_tck);
      end
      if (j < 41) @(negedge clk);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL tms_ready_at_end: cmd_ready=%b required 1", cmd_ready);
    end
    issue(1'b0, 6'd1, 32'h0, 1'b0);
    wait_idle("tms", 40);
    vectors++;
    if (rise_cnt - base != 6) begin
      miscompares++;
      $display("FAIL tms_pulses: %0d tck pulses required 6", rise_cnt - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_tms = (k < 5);
        vectors++;
        if (tms_hist[base + k] !== exp_tms) begin
          miscompares++;
          $display("FAIL tms_seq: rise %0d tms=%b required %b", k, tms_hist[base + k], exp_tms);
        end
      end
    end
    vectors++;
    if (tap_state != RTI || tms !== 1'b0) begin
      miscompares++;
      $display("FAIL tms_tap_rti: tap=%0d tms=%b required %0d 0", tap_state, tms, RTI);
    end
  endtask

  task automatic test_shift8();
    int         base;
    logic [7:0] got_tdi;
    logic [7:0] got_tms;
    loop_mode = 1'b0;
    tdo_pat   = 32'h0000_003C;
    fall_base = fall_cnt;
    base      = rise_cnt;
    exp_q.push_back(32'h0000_003C);
    issue(1'b1, 6'd8, 32'h0000_00A5, 1'b1);
    wait_rsp("shift8", 90, 65);
    vectors++;
    if (rise_cnt - base != 8) begin
      miscompares++;
      $display("FAIL shift8_pulses: %0d tck pulses required 8", rise_cnt - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        got_tdi[k] = tdi_hist[base + k];
        got_tms[k] = tms_hist[base + k];
      end
      vectors++;
      if (got_tdi !== 8'hA5 || got_tms !== 8'h80) begin
        miscompares++;
        $display("FAIL shift8_pins: tdi LSB-first=%h tms=%h required a5 80", got_tdi, got_tms);
      end
    end
    ack("shift8");
  endtask

  task automatic test_loop32();
    int bad;
    loop_mode = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    issue(1'b1, 6'd32, 32'hDEAD_BEEF, 1'b0);
    wait_rsp("loop32", 300, 257);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || cmd_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL loop32_hold: %0d unstable cycles required 0 (rv=%b data=%h rdy=%b)", bad,
               rsp_valid, rsp_data, cmd_ready);
    end
    ack("loop32");
  endtask

  task automatic test_boundaries();
    int base;
    base = rise_cnt;
    exp_q.push_back('0);
    issue(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b1);
    wait_rsp("len0_shift", 5, 1);
    vectors++;
    if (rise_cnt != base) begin
      miscompares++;
      $display("FAIL len0_shift_tck: %0d tck pulses required 0", rise_cnt - base);
    end
    ack("len0_shift");
    issue(1'b0, 6'd0, 32'hFFFF_FFFF, 1'b0);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rise_cnt != base) begin
      miscompares++;
      $display("FAIL len0_tms: cmd_ready=%b busy=%b pulses=%0d required 1 0 0", cmd_ready, busy,
               rise_cnt - base);
    end
    loop_mode = 1'b1;
    exp_q.push_back(32'h0F0F_1234);
    issue(1'b1, 6'd40, 32'h0F0F_1234, 1'b0);
    wait_rsp("len40", 300, 257);
    vectors++;
    if (rise_cnt - base != 32) begin
      miscompares++;
      $display("FAIL len40_pulses: %0d tck pulses required 32", rise_cnt - base);
    end
    ack("len40");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[3];
    int          acc[3];
    int          k;
    int          j;
    int          base;
    logic [5:0]  got_tms;
    d[0] = 32'h1;
    d[1] = 32'h2;
    d[2] = 32'h3;
    base = rise_cnt;
    k    = 0;
    j    = 0;
    cmd_type  = 1'b0;
    cmd_len   = 6'd2;
    cmd_exit  = 1'b0;
    cmd_data  = d[0];
    cmd_valid = 1'b1;
    while (k < 3 && j < 100) begin
      if (cmd_ready === 1'b1) begin
        acc[k] = j;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) cmd_data = d[k];
        else cmd_valid = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    cmd_valid = 1'b0;
    vectors++;
    if (k != 3) begin
      miscompares++;
      $display("FAIL b2b_accepts: %0d accepted required 3", k);
    end else begin
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (acc[m] != 17 * m) begin
          miscompares++;
          $display("FAIL b2b_accept_cycle: cmd %0d at cycle %0d required %0d", m, acc[m],
                   17 * m);
        end
      end
    end
    wait_idle("b2b", 40);
    vectors++;
    if (rise_cnt - base != 6) begin
      miscompares++;
      $display("FAIL b2b_pulses: %0d tck pulses required 6", rise_cnt - base);
    end else begin
      for (int m = 0; m < 6; m++) got_tms[m] = tms_hist[base + m];
      vectors++;
      if (got_tms !== 6'b111001) begin
        miscompares++;
        $display("FAIL b2b_tms: tms LSB-first=%b required 111001", got_tms);
      end
    end
  endtask

  initial begin
    resetb    = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    cmd_exit  = 1'b0;
    rsp_ready = 1'b0;
    loop_mode = 1'b1;
    tdo_pat   = '0;
    fall_base = 0;
    test_reset();
    test_tms();
    test_shift8();
    test_loop32();
    test_boundaries();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d responses missing required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
